// File: rtl/timer_seq_ctrl.sv
// timer_seq_ctrl: Avalon-MM master sequencing config writes, irq acks and snapshot reads onto one timer slave
//   clk, reset                 : sole clock, synchronous active-high reset
//   cfg_valid/ready/done       : reprogram handshake; cfg_period/cont/ito captured on acceptance
//   snap_req/valid/value       : 32-bit counter snapshot (present only with TIMER_SEQ_SNAPSHOT_EN)
//   tick, tick_count           : pulse and wrapping count of acknowledged timeouts since last cfg
//   tmr_*                      : Avalon-MM master port to the timer slave, tmr_irq level input
//   Build macro TIMER_SEQ_SNAPSHOT_EN enables the snapshot path; undefined removes it.
module timer_seq_ctrl #(
    parameter int TICK_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [31:0]       cfg_period,
    input  logic              cfg_cont,
    input  logic              cfg_ito,
    output logic              cfg_done,
    input  logic              snap_req,
    output logic              snap_valid,
    output logic [31:0]       snap_value,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic [2:0]        tmr_address,
    output logic              tmr_chipselect,
    output logic              tmr_write_n,
    output logic [15:0]       tmr_writedata,
    input  logic [15:0]       tmr_readdata,
    input  logic              tmr_irq
);
`ifdef TIMER_SEQ_SNAPSHOT_EN
    typedef enum logic [3:0] {IDLE, W_STOP, W_PL, W_PH, W_CTRL, W_ACK, W_SNAP, R_SNL, R_SNH, CAP} state_t;
`else
    typedef enum logic [2:0] {IDLE, W_STOP, W_PL, W_PH, W_CTRL, W_ACK} state_t;
`endif
    state_t state, nxt;
    logic [31:0] period;
    logic cont, ito;
    logic cs_d, wn_d;
    logic [2:0] addr_d;
    logic [15:0] wd_d;
`ifdef TIMER_SEQ_SNAPSHOT_EN
    logic snap_pend;
    logic [15:0] snap_l;
`else
    logic unused_snap;
    assign unused_snap = ^{snap_req, tmr_readdata};
    assign snap_valid = 1'b0;
    assign snap_value = '0;
`endif
    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (tmr_irq) nxt = W_ACK;
                else if (cfg_valid && cfg_ready) nxt = W_STOP;
`ifdef TIMER_SEQ_SNAPSHOT_EN
                else if (snap_pend) nxt = W_SNAP;
`endif
            end
            W_STOP: nxt = W_PL;
            W_PL:   nxt = W_PH;
            W_PH:   nxt = W_CTRL;
            W_CTRL: nxt = IDLE;
            W_ACK:  nxt = IDLE;
`ifdef TIMER_SEQ_SNAPSHOT_EN
            W_SNAP: nxt = R_SNL;
            R_SNL:  nxt = R_SNH;
            R_SNH:  nxt = CAP;
            CAP:    nxt = IDLE;
`endif
            default: nxt = IDLE;
        endcase
    end
    // Bus fields are decoded from the next state so they can be registered
    // and still line up with the state that owns the bus cycle.
    always_comb begin
        cs_d = 1'b1;
        wn_d = 1'b0;
        addr_d = 3'd0;
        wd_d = 16'h0000;
        case (nxt)
            W_STOP: begin addr_d = 3'd1; wd_d = 16'h0008; end
            W_PL:   begin addr_d = 3'd2; wd_d = period[15:0]; end
            W_PH:   begin addr_d = 3'd3; wd_d = period[31:16]; end
            W_CTRL: begin addr_d = 3'd1; wd_d = {12'b0, 1'b0, 1'b1, cont, ito}; end
            W_ACK:  addr_d = 3'd0;
`ifdef TIMER_SEQ_SNAPSHOT_EN
            W_SNAP: addr_d = 3'd4;
            R_SNL:  begin addr_d = 3'd4; wn_d = 1'b1; end
            R_SNH:  begin addr_d = 3'd5; wn_d = 1'b1; end
`endif
            default: begin cs_d = 1'b0; wn_d = 1'b1; end
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cfg_ready <= 1'b0;
            cfg_done <= 1'b0;
            tick <= 1'b0;
            tick_count <= '0;
            period <= '0;
            cont <= 1'b0;
            ito <= 1'b0;
            tmr_chipselect <= 1'b0;
            tmr_write_n <= 1'b1;
            tmr_address <= 3'd0;
            tmr_writedata <= 16'h0000;
        end else begin
            state <= nxt;
            cfg_ready <= (nxt == IDLE);
            cfg_done <= (state == W_CTRL);
            tick <= (state == W_ACK);
            if (state == W_CTRL) tick_count <= '0;
            else if (state == W_ACK) tick_count <= tick_count + TICK_W'(1);
            if (state == IDLE && nxt == W_STOP) begin
                period <= cfg_period;
                cont <= cfg_cont;
                ito <= cfg_ito;
            end
            tmr_chipselect <= cs_d;
            tmr_write_n <= wn_d;
            tmr_address <= addr_d;
            tmr_writedata <= wd_d;
        end
    end
`ifdef TIMER_SEQ_SNAPSHOT_EN
    // Read data lags the address by one cycle: R_SNH sees snap_l, CAP sees snap_h.
    // Requests during W_SNAP..R_SNH merge into the running snapshot; CAP re-arms.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_pend <= 1'b0;
            snap_l <= 16'h0000;
            snap_valid <= 1'b0;
            snap_value <= '0;
        end else begin
            snap_valid <= (state == CAP);
            if (state == R_SNH) snap_l <= tmr_readdata;
            if (state == CAP) snap_value <= {tmr_readdata, snap_l};
            if (nxt == W_SNAP) snap_pend <= 1'b0;
            else if (snap_req && !(state inside {W_SNAP, R_SNL, R_SNH})) snap_pend <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_timer_seq_ctrl.sv
// tb_timer_seq_ctrl: directed bench for timer_seq_ctrl with a small timer slave model
//   main instance uses TICK_W=16; second instance uses TICK_W=4 for the wrap case
module tb_timer_seq_ctrl;
    localparam logic [20:0] BUS_IDLE = 21'h080000;
    logic clk = 1'b0, reset = 1'b1;
    logic cfg_valid = 1'b0, cfg_cont = 1'b0, cfg_ito = 1'b0, snap_req = 1'b0;
    logic [31:0] cfg_period = '0;
    logic cfg_ready, cfg_done, snap_valid, tick, tmr_chipselect, tmr_write_n, tmr_irq;
    logic [31:0] snap_value;
    logic [15:0] tick_count, tmr_writedata, tmr_readdata;
    logic [2:0] tmr_address;
    logic irq_raise = 1'b0;
    logic [31:0] tmr_cnt = '0, snap_lat = '0;
    logic irq4, raise4 = 1'b0, cfg_ready4, cfg_done4, snap_valid4, tick4, cs4, wn4;
    logic [31:0] sv4;
    logic [3:0] tc4;
    logic [2:0] a4;
    logic [15:0] wd4;
    int cyc = 0, checks = 0, errors = 0;
    int base, n, ne, pulses, act;
    int log_c[$];
    logic [20:0] log_b[$];
    int e_off[8];
    logic [20:0] e_bus[8];

    timer_seq_ctrl #(.TICK_W(16)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_period(cfg_period), .cfg_cont(cfg_cont), .cfg_ito(cfg_ito), .cfg_done(cfg_done),
        .snap_req(snap_req), .snap_valid(snap_valid), .snap_value(snap_value),
        .tick(tick), .tick_count(tick_count), .tmr_address(tmr_address),
        .tmr_chipselect(tmr_chipselect), .tmr_write_n(tmr_write_n),
        .tmr_writedata(tmr_writedata), .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq)
    );

    timer_seq_ctrl #(.TICK_W(4)) dut4 (
        .clk(clk), .reset(reset), .cfg_valid(1'b0), .cfg_ready(cfg_ready4),
        .cfg_period(32'h0), .cfg_cont(1'b0), .cfg_ito(1'b0), .cfg_done(cfg_done4),
        .snap_req(1'b0), .snap_valid(snap_valid4), .snap_value(sv4),
        .tick(tick4), .tick_count(tc4), .tmr_address(a4),
        .tmr_chipselect(cs4), .tmr_write_n(wn4),
        .tmr_writedata(wd4), .tmr_readdata(16'h0), .tmr_irq(irq4)
    );

    always #5 clk = ~clk;

    // Timer slave model: ack write clears irq, addr-4 write latches the counter,
    // reads return registered data one cycle later. Every bus cycle is logged.
    always @(posedge clk) begin
        if (tmr_chipselect) begin
            log_c.push_back(cyc);
            log_b.push_back({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata});
        end
        cyc <= cyc + 1;
        if (reset) begin
            tmr_irq <= 1'b0;
            tmr_readdata <= 16'h0;
            irq4 <= 1'b0;
        end else begin
            if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd0) tmr_irq <= 1'b0;
            else if (irq_raise) tmr_irq <= 1'b1;
            if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd4) snap_lat <= tmr_cnt;
            tmr_readdata <= (tmr_chipselect && tmr_write_n) ?
                (tmr_address == 3'd4 ? snap_lat[15:0] : tmr_address == 3'd5 ? snap_lat[31:16] : 16'hDEAD) : 16'hBEEF;
            if (cs4 && !wn4 && a4 == 3'd0) irq4 <= 1'b0;
            else if (raise4) irq4 <= 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [20:0] bw(input logic [2:0] a, input logic [15:0] d);
        return {2'b10, a, d};
    endfunction

    function automatic logic [20:0] br(input logic [2:0] a);
        return {2'b11, a, 16'h0};
    endfunction

    function automatic logic [20:0] bus();
        return {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata};
    endfunction

`ifdef TIMER_SEQ_SNAPSHOT_EN
    task automatic snap_run(input logic [31:0] v, input bit second_req);
        tmr_cnt = v;
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        step();
        chk("snap_wsnap", bus(), bw(3'd4, 16'h0));
        step();
        chk("snap_rsnl", bus(), br(3'd4));
        if (second_req) snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        chk("snap_rsnh", bus(), br(3'd5));
        step();
        chk("snap_cap_bus", bus(), BUS_IDLE);
        chk("snap_cap_valid", snap_valid, 1'b0);
        step();
        chk("snap_valid", snap_valid, 1'b1);
        chk("snap_value", snap_value, v);
        pulses = 0;
        act = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            pulses += int'(snap_valid);
            act += int'(tmr_chipselect);
        end
        chk("snap_no_extra_valid", pulses, 0);
        chk("snap_no_extra_bus", act, 0);
    endtask
`endif

    initial begin
        step();
        step();
        chk("rst_cfg_ready", cfg_ready, 1'b0);
        chk("rst_cfg_done", cfg_done, 1'b0);
        chk("rst_tick", tick, 1'b0);
        chk("rst_tick_count", tick_count, 16'h0);
        chk("rst_snap_valid", snap_valid, 1'b0);
        chk("rst_snap_value", snap_value, 32'h0);
        chk("rst_bus", bus(), BUS_IDLE);
        reset = 1'b0;
        step();
        chk("idle_cfg_ready", cfg_ready, 1'b1);

        // config sequence; inputs changed after acceptance must be ignored
        cfg_valid = 1'b1;
        cfg_period = 32'h0001_86A0;
        cfg_cont = 1'b1;
        cfg_ito = 1'b1;
        step();
        cfg_valid = 1'b0;
        cfg_period = 32'hFFFF_FFFF;
        cfg_cont = 1'b0;
        cfg_ito = 1'b0;
        chk("cfg_stop", bus(), bw(3'd1, 16'h0008));
        chk("cfg_ready_busy", cfg_ready, 1'b0);
        step();
        chk("cfg_pl", bus(), bw(3'd2, 16'h86A0));
        step();
        chk("cfg_ph", bus(), bw(3'd3, 16'h0001));
        step();
        chk("cfg_ctrl", bus(), bw(3'd1, 16'h0007));
        chk("cfg_done_early", cfg_done, 1'b0);
        step();
        chk("cfg_done", cfg_done, 1'b1);
        chk("cfg_end_bus", bus(), BUS_IDLE);
        chk("cfg_tick_count", tick_count, 16'h0);
        step();
        chk("cfg_done_pulse", cfg_done, 1'b0);

        // three irq acknowledges
        for (int i = 1; i <= 3; i++) begin
            irq_raise = 1'b1;
            step();
            irq_raise = 1'b0;
            step();
            chk("ack_bus", bus(), bw(3'd0, 16'h0));
            chk("ack_tick_early", tick, 1'b0);
            step();
            chk("ack_tick", tick, 1'b1);
            chk("ack_tick_count", tick_count, 16'(i));
            chk("ack_idle", bus(), BUS_IDLE);
            step();
            chk("ack_tick_pulse", tick, 1'b0);
            chk("ack_no_double", bus(), BUS_IDLE);
        end

        // irq, cfg and snap in the same IDLE cycle
        irq_raise = 1'b1;
        step();
        irq_raise = 1'b0;
        base = cyc;
        cfg_valid = 1'b1;
        cfg_period = 32'h1234_5678;
        cfg_cont = 1'b0;
        cfg_ito = 1'b1;
        snap_req = 1'b1;
        tmr_cnt = 32'h0BAD_F00D;
        step();
        snap_req = 1'b0;
        step();
        chk("all_tick", tick, 1'b1);
        chk("all_tick_count", tick_count, 16'd4);
        step();
        cfg_valid = 1'b0;
        step();
        step();
        step();
        step();
        chk("all_cfg_done", cfg_done, 1'b1);
        chk("all_tick_clear", tick_count, 16'h0);
        for (int i = 0; i < 6; i++) step();
        e_off = '{1, 3, 4, 5, 6, 8, 9, 10};
        e_bus = '{bw(3'd0, 16'h0), bw(3'd1, 16'h0008), bw(3'd2, 16'h5678), bw(3'd3, 16'h1234),
                  bw(3'd1, 16'h0005), bw(3'd4, 16'h0), br(3'd4), br(3'd5)};
`ifdef TIMER_SEQ_SNAPSHOT_EN
        ne = 8;
`else
        ne = 5;
`endif
        n = 0;
        foreach (log_c[i]) begin
            if (log_c[i] > base) begin
                if (n < ne) begin
                    chk("order_cycle", log_c[i] - base, e_off[n]);
                    chk("order_bus", log_b[i], e_bus[n]);
                end
                n++;
            end
        end
        chk("order_count", n, ne);

`ifdef TIMER_SEQ_SNAPSHOT_EN
        chk("all_snap_value", snap_value, 32'h0BAD_F00D);
        snap_run(32'h0000_C34F, 1'b1);
        snap_run(32'hABCD_1234, 1'b0);
`else
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        pulses = 0;
        act = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            pulses += int'(snap_valid);
            act += int'(tmr_chipselect);
        end
        chk("nosnap_valid", pulses, 0);
        chk("nosnap_bus", act, 0);
        chk("nosnap_value", snap_value, 32'h0);
`endif

        // reset during W_PH, then a fresh config
        cfg_valid = 1'b1;
        cfg_period = 32'hAAAA_5555;
        cfg_cont = 1'b1;
        cfg_ito = 1'b0;
        step();
        cfg_valid = 1'b0;
        step();
        step();
        chk("rstmid_ph", bus(), bw(3'd3, 16'hAAAA));
        reset = 1'b1;
        step();
        chk("rstmid_bus", bus(), BUS_IDLE);
        chk("rstmid_ready", cfg_ready, 1'b0);
        reset = 1'b0;
        pulses = 0;
        act = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            pulses += int'(cfg_done);
            act += int'(tmr_chipselect);
        end
        chk("rstmid_no_done", pulses, 0);
        chk("rstmid_no_ctrl", act, 0);
        cfg_valid = 1'b1;
        cfg_period = 32'h0000_0010;
        cfg_cont = 1'b0;
        cfg_ito = 1'b0;
        step();
        cfg_valid = 1'b0;
        chk("recfg_stop", bus(), bw(3'd1, 16'h0008));
        step();
        chk("recfg_pl", bus(), bw(3'd2, 16'h0010));
        step();
        chk("recfg_ph", bus(), bw(3'd3, 16'h0000));
        step();
        chk("recfg_ctrl", bus(), bw(3'd1, 16'h0004));
        step();
        chk("recfg_done", cfg_done, 1'b1);

        // TICK_W=4 wrap after 17 acks
        pulses = 0;
        for (int i = 1; i <= 17; i++) begin
            raise4 = 1'b1;
            step();
            raise4 = 1'b0;
            step();
            step();
            pulses += int'(tick4);
            step();
            pulses += int'(tick4);
            if (i == 15) chk("wrap_15", tc4, 4'd15);
        end
        chk("wrap_ticks", pulses, 17);
        chk("wrap_count", tc4, 4'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
